// File: rtl/fifo_frame_reader.sv
// fifo_frame_reader: pops one IMG_W x IMG_H frame from the window FIFO and streams it with x/y indices and frame markers.
// Define FRAME_READER_TIMEOUT_EN to abort a frame after TIMEOUT_CYCLES READ cycles without a handshake.
module fifo_frame_reader #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int DATA_W = 8,
    parameter int IDX_W  = 10
`ifdef FRAME_READER_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_fifoEmpty,
    input  logic [DATA_W-1:0] i_fifoData,
    output logic              o_fifoRead,
    output logic [DATA_W-1:0] o_pixel,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [IDX_W-1:0]  o_xIndex,
    output logic [IDX_W-1:0]  o_yIndex,
    output logic              o_sof,
    output logic              o_eol,
    output logic              o_eof,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error
);
    localparam int TOTAL = IMG_W * IMG_H;
    localparam int CNT_W = $clog2(TOTAL + 1);
    typedef enum logic [1:0] {IDLE, READ, DONE} state_t;
    state_t state, state_nxt;
    logic [CNT_W-1:0] req_cnt;
    logic inflight;
    logic [DATA_W-1:0] buf_mem [2];
    logic rd_ptr, wr_ptr;
    logic [1:0] buf_cnt;
    logic [IDX_W-1:0] x_cnt, y_cnt;
    logic pop, last, timeout, x_end, y_end;
    logic [2:0] occ;
    assign o_valid  = buf_cnt != 2'd0;
    assign pop      = o_valid & i_ready;
    assign x_end    = x_cnt == IDX_W'(IMG_W - 1);
    assign y_end    = y_cnt == IDX_W'(IMG_H - 1);
    assign last     = pop & x_end & y_end;
    assign occ      = 3'(buf_cnt) + 3'(inflight) - 3'(pop);
    // Issue only when the returning word is guaranteed a free buffer slot
    assign o_fifoRead = !i_reset && !timeout && state == READ && !i_fifoEmpty
                        && req_cnt < CNT_W'(TOTAL) && occ < 3'd2;
    assign o_pixel  = buf_mem[rd_ptr];
    assign o_xIndex = x_cnt;
    assign o_yIndex = y_cnt;
    assign o_sof    = o_valid & x_cnt == '0 & y_cnt == '0;
    assign o_eol    = o_valid & x_end;
    assign o_eof    = o_valid & x_end & y_end;
    assign o_busy   = state != IDLE;
    assign o_done   = state == DONE;
    assign o_error  = timeout;
`ifdef FRAME_READER_TIMEOUT_EN
    localparam int ST_W = $clog2(TIMEOUT_CYCLES);
    logic [ST_W-1:0] stall_cnt;
    always_ff @(posedge i_clk) begin
        if (i_reset || state != READ || pop)
            stall_cnt <= '0;
        else
            stall_cnt <= stall_cnt + 1'b1;
    end
    assign timeout = state == READ && !pop && stall_cnt == ST_W'(TIMEOUT_CYCLES - 1);
`else
    assign timeout = 1'b0;
`endif
    always_comb begin
        state_nxt = state == IDLE ? (i_start ? READ : IDLE)
                  : state == READ ? (timeout ? IDLE : last ? DONE : READ)
                  : IDLE;
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= IDLE;
            req_cnt    <= '0;
            inflight   <= 1'b0;
            buf_cnt    <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            x_cnt      <= '0;
            y_cnt      <= '0;
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= o_fifoRead;
            if (state == IDLE && i_start) begin
                req_cnt <= '0;
                x_cnt   <= '0;
                y_cnt   <= '0;
            end else begin
                if (o_fifoRead)
                    req_cnt <= req_cnt + 1'b1;
                if (pop) begin
                    x_cnt <= x_end ? '0 : x_cnt + 1'b1;
                    if (x_end)
                        y_cnt <= y_cnt + 1'b1;
                end
            end
            // A timeout flush also drops the word returning this cycle
            if (timeout) begin
                buf_cnt <= '0;
                rd_ptr  <= 1'b0;
                wr_ptr  <= 1'b0;
            end else begin
                if (inflight) begin
                    buf_mem[wr_ptr] <= i_fifoData;
                    wr_ptr          <= ~wr_ptr;
                end
                if (pop)
                    rd_ptr <= ~rd_ptr;
                buf_cnt <= buf_cnt + 2'(inflight) - 2'(pop);
            end
        end
    end
endmodule

// File: tb/tb_fifo_frame_reader.sv
// tb_fifo_frame_reader: directed scenarios for fifo_frame_reader against a 1-cycle-latency FIFO model.
module tb_fifo_frame_reader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i_start = 1'b0;
    logic i_ready = 1'b0;
    logic force_empty = 1'b0;
    logic fifo_rewind = 1'b0;
    logic fifo_empty, fifo_read, valid, sof, eol, eof, busy, done, err;
    logic [7:0] fifo_data, pixel;
    logic [9:0] x, y;
    int rptr = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_frame_reader dut (
        .i_clk(clk), .i_reset(rst), .i_start(i_start), .i_fifoEmpty(fifo_empty),
        .i_fifoData(fifo_data), .o_fifoRead(fifo_read), .o_pixel(pixel), .o_valid(valid),
        .i_ready(i_ready), .o_xIndex(x), .o_yIndex(y), .o_sof(sof), .o_eol(eol),
        .o_eof(eof), .o_busy(busy), .o_done(done), .o_error(err)
    );

    // FIFO preloaded with 4096 bytes, value = index mod 256
    assign fifo_empty = force_empty || rptr >= 4096;
    always @(posedge clk) begin
        fifo_data <= fifo_read ? 8'(rptr) : 8'hEE;
        rptr      <= fifo_rewind ? 0 : rptr + int'(fifo_read);
    end

    task automatic test_reset();
        rst = 1'b1;
        i_start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({fifo_read, valid, sof, eol, eof, busy, done, err, x, y, pixel} !== 36'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", {fifo_read, valid, sof, eol, eof, busy, done, err, x, y, pixel});
        end
        rst = 1'b0;
        i_start = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_beats_start busy got %b want 0", busy);
        end
    endtask

    task automatic run_frame(input bit toggle, input int empty_at, input int start_at, input int reset_at);
        int exp_idx = 0;
        int reads = 0;
        int streak = 0;
        int max_streak = 0;
        int empty_left = 0;
        int cyc = 0;
        bit empty_done = 0;
        bit start_done = 0;
        logic [30:0] exp_v;
        @(negedge clk);
        fifo_rewind = 1'b1;
        i_start = 1'b1;
        i_ready = 1'b1;
        @(negedge clk);
        fifo_rewind = 1'b0;
        i_start = 1'b0;
        while (exp_idx < 4096 && cyc < 20000) begin
            i_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            if (exp_idx == empty_at && !empty_done) begin
                empty_left = 10;
                empty_done = 1;
            end
            force_empty = empty_left > 0;
            i_start = exp_idx == start_at && !start_done;
            if (i_start) start_done = 1;
            if (exp_idx == reset_at) begin
                rst = 1'b1;
                fifo_rewind = 1'b1;
                @(negedge clk);
                #1;
                checks++;
                if ({fifo_read, valid, sof, eol, eof, busy, done, err, x, y, pixel} !== 36'd0) begin
                    errors++;
                    $display("FAIL reset_midframe got %h want 0", {fifo_read, valid, sof, eol, eof, busy, done, err, x, y, pixel});
                end
                rst = 1'b0;
                fifo_rewind = 1'b0;
                force_empty = 1'b0;
                return;
            end
            #1;
            if (valid) begin
                exp_v = {8'(exp_idx), 10'(exp_idx % 64), 10'(exp_idx / 64), exp_idx == 0, exp_idx % 64 == 63, exp_idx == 4095};
                checks++;
                if ({pixel, x, y, sof, eol, eof} !== exp_v) begin
                    errors++;
                    $display("FAIL pixel idx=%0d got %h want %h", exp_idx, {pixel, x, y, sof, eol, eof}, exp_v);
                end
            end
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL early_done idx=%0d got %b want 0", exp_idx, done);
            end
            if (fifo_read) reads++;
            if (force_empty) begin
                checks++;
                if (fifo_read !== 1'b0) begin
                    errors++;
                    $display("FAIL read_while_empty got %b want 0", fifo_read);
                end
            end
            if (empty_left == 1) begin
                checks++;
                if (valid !== 1'b0) begin
                    errors++;
                    $display("FAIL drain_valid got %b want 0", valid);
                end
            end
            checks++;
            if (reads - exp_idx - int'(valid && i_ready) > 2) begin
                errors++;
                $display("FAIL occupancy got %0d want <=2", reads - exp_idx - int'(valid && i_ready));
            end
            streak = fifo_read ? streak + 1 : 0;
            if (streak > max_streak) max_streak = streak;
            if (valid && i_ready) exp_idx++;
            if (empty_left > 0) empty_left--;
            @(negedge clk);
            cyc++;
        end
        force_empty = 1'b0;
        i_start = 1'b0;
        i_ready = 1'b1;
        #1;
        checks++;
        if (exp_idx != 4096) begin
            errors++;
            $display("FAIL frame_len got %0d want 4096", exp_idx);
        end
        checks++;
        if ({done, busy, valid} !== 3'b110) begin
            errors++;
            $display("FAIL done_pulse got %b want 110", {done, busy, valid});
        end
        checks++;
        if (reads != 4096) begin
            errors++;
            $display("FAIL read_count got %0d want 4096", reads);
        end
        if (!toggle && empty_at < 0) begin
            checks++;
            if (max_streak != 4096) begin
                errors++;
                $display("FAIL read_streak got %0d want 4096", max_streak);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL after_done got %b want 00", {done, busy});
        end
    endtask

    task automatic test_stream();
        run_frame(0, -1, -1, -1);
    endtask

    task automatic test_backpressure();
        run_frame(1, -1, -1, -1);
    endtask

    task automatic test_empty_stall();
        run_frame(0, 100, -1, -1);
    endtask

    task automatic test_reset_midframe();
        run_frame(0, -1, -1, 2000);
        run_frame(0, -1, -1, -1);
    endtask

    task automatic test_start_ignored();
        run_frame(0, -1, 500, -1);
    endtask

    task automatic test_timeout();
        int exp_idx = 0;
        int cyc = 0;
        int err_cnt = 0;
        int done_cnt = 0;
        @(negedge clk);
        fifo_rewind = 1'b1;
        i_start = 1'b1;
        i_ready = 1'b1;
        @(negedge clk);
        fifo_rewind = 1'b0;
        i_start = 1'b0;
        while (exp_idx < 300 && cyc < 1000) begin
            #1;
            if (valid && i_ready) exp_idx++;
            @(negedge clk);
            cyc++;
        end
        i_ready = 1'b0;
        #1;
        checks++;
        if ({valid, pixel, x, y} !== {1'b1, 8'd44, 10'd44, 10'd4}) begin
            errors++;
            $display("FAIL stall_head got %h want %h", {valid, pixel, x, y}, {1'b1, 8'd44, 10'd44, 10'd4});
        end
        for (int i = 0; i < 1030; i++) begin
            @(negedge clk);
            #1;
            err_cnt += int'(err);
            done_cnt += int'(done);
        end
`ifdef FRAME_READER_TIMEOUT_EN
        checks++;
        if ({err_cnt, done_cnt} !== {32'd1, 32'd0}) begin
            errors++;
            $display("FAIL timeout_pulses err=%0d done=%0d want 1 0", err_cnt, done_cnt);
        end
        checks++;
        if ({busy, valid} !== 2'b00) begin
            errors++;
            $display("FAIL timeout_idle got %b want 00", {busy, valid});
        end
`else
        checks++;
        if ({err_cnt, done_cnt} !== {32'd0, 32'd0}) begin
            errors++;
            $display("FAIL no_timeout err=%0d done=%0d want 0 0", err_cnt, done_cnt);
        end
        checks++;
        if ({busy, valid, pixel, x, y} !== {1'b1, 1'b1, 8'd44, 10'd44, 10'd4}) begin
            errors++;
            $display("FAIL held_pixel got %h want %h", {busy, valid, pixel, x, y}, {1'b1, 1'b1, 8'd44, 10'd44, 10'd4});
        end
        i_ready = 1'b1;
        cyc = 0;
        while (done !== 1'b1 && cyc < 5000) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL resume_done got %b want 1", done);
        end
`endif
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_empty_stall();
        test_reset_midframe();
        test_start_ignored();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
